// File: rtl/serial_mag_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// the one-hot greater/equal/less result record.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE  = '{g: 1'b0, e: 1'b0, l: 1'b0};
  localparam cmp_res_t RES_EQUAL = '{g: 1'b0, e: 1'b1, l: 1'b0};

  // Result for a slice known to differ: exactly one of gt/lt is set.
  function automatic cmp_res_t res_from_slice(input logic gt, input logic lt);
    cmp_res_t r;
    r.g = gt;
    r.e = 1'b0;
    r.l = lt;
    return r;
  endfunction

endpackage : cmp_pkg

// File: rtl/serial_mag_comparator_slice_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice; gt=lt=0 means equal.
module slice_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule : slice_cmp

// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: scans DIGIT-bit slices MSB-first, stops at
// the first differing slice and returns one-hot g/e/l via valid/ready.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_params
      $error("serial_mag_comparator: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  cmp_res_t         res_q, res_d;
  logic             out_valid_q, out_valid_d;

  logic [DIGIT-1:0] slice_x, slice_y;
  logic             slice_gt, slice_lt;

  // Slice mux. In signed mode flipping the sign bit maps two's-complement
  // order onto unsigned order; it only matters in the top slice.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    slice_x = '0;
    slice_y = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_x = a_q[i*DIGIT +: DIGIT];
        slice_y = b_q[i*DIGIT +: DIGIT];
      end
    end
    if (mode_q && (idx_q == IDX_TOP)) begin
      slice_x[DIGIT-1] = ~slice_x[DIGIT-1];
      slice_y[DIGIT-1] = ~slice_y[DIGIT-1];
    end
  end

  slice_cmp #(.DIGIT(DIGIT)) u_slice_cmp (
    .x  (slice_x),
    .y  (slice_y),
    .gt (slice_gt),
    .lt (slice_lt)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = signed_mode;
          idx_d   = IDX_TOP;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (slice_gt || slice_lt) begin
          res_d       = res_from_slice(slice_gt, slice_lt);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          res_d       = RES_EQUAL;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d       = RES_NONE;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_d       = RES_NONE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: the operand registers are plain flops, not a memory, so they reset to 0 with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      idx_q       <= IDX_TOP;
      res_q       <= RES_NONE;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign g         = res_q.g;
  assign e         = res_q.e;
  assign l         = res_q.l;

endmodule : serial_mag_comparator
